clint_smp: RTL and testbench
============================

Name: clint_smp

Overview:
- Per-hart core-local interruptor feeding the multi-hart RV cluster; sits directly upstream of the cluster's w_mtip/w_msip/w_mtime inputs.
- Holds one shared 64-bit mtime, one 64-bit mtimecmp and one msip bit per hart.
- Outputs per-hart timer and software interrupt vectors.
- Programmed through a simple word-wide MMIO slave port driven by the memory controller.

Parameters:
- N_HARTS, 2, number of harts served (1..16).
- TICK_DIV, 1, CLK cycles per mtime increment (>=1).

Ports:
- CLK input 1 system clock
- RST input 1 synchronous active-high reset
- w_req input 1 MMIO access strobe, one cycle per access
- w_we input 1 1=write, 0=read (valid with w_req)
- w_addr input 16 byte offset within CLINT window; bits [1:0] ignored
- w_wdata input 32 write data
- r_rdata output 32 read data, registered
- r_rvalid output 1 read data valid pulse
- r_mtip output N_HARTS timer interrupt pending per hart
- r_msip output N_HARTS software interrupt pending per hart
- w_mtime output 64 current mtime value

Behaviour:
- Register map (word offsets, h = hart index):
  - msip[h] at 0x0000+4h; only bit 0 is stored, other bits read 0.
  - mtimecmp[h] low at 0x4000+8h, high at 0x4004+8h.
  - mtime low at 0xBFF8, high at 0xBFFC.
  - Any other offset, including h >= N_HARTS, is unmapped: writes are ignored and reads return 0.
- Reset values (RST=1 at a CLK edge): mtime=0, prescaler=0, all mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, all msip=0, r_mtip=0, r_rdata=0, r_rvalid=0.
- Slave port:
  - No backpressure; every w_req is accepted in its cycle.
  - Write takes effect at the same edge.
  - Read: r_rdata and r_rvalid=1 appear one cycle after w_req. r_rvalid is a single-cycle pulse; r_rdata holds its value until the next read.
  - A read returns register contents from before any write at the same edge. Back-to-back reads are allowed every cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - mtime increments by 1 on the cycle the prescaler equals TICK_DIV-1. With TICK_DIV=1, mtime increments every cycle.
- mtime arithmetic:
  - Full 64-bit, wraps from 2^64-1 to 0.
  - A software write to either mtime half takes priority over the increment in that cycle. The written half takes w_wdata; the other half keeps its pre-increment value with no carry.
  - The prescaler is not reset by mtime writes.
- r_mtip[h]:
  - Registered (mtime >= mtimecmp[h]), unsigned 64-bit, evaluated on pre-edge values.
  - Latency is one cycle after mtime or mtimecmp changes.
  - Level-sensitive: it clears one cycle after mtimecmp is raised above mtime.
- r_msip[h] is the stored msip bit, updated at the write edge.
- w_mtime is the mtime register, combinational from the flop.
- Reset mid-operation: RST overrides any w_req in the same cycle, the access is dropped, and no r_rvalid is generated the next cycle.

Test Plan:
- Reset values: apply RST for 2 cycles, release, read 0xBFF8 -> r_rvalid next cycle with r_rdata=0. Then read 0x4000 -> 0xFFFFFFFF. r_mtip=0 and r_msip=0 throughout.
- Timer fire, N_HARTS=2, TICK_DIV=1: write 0x4008=0x00000020, 0x400C=0 (hart 1 mtimecmp=32) -> r_mtip=2'b10 exactly one cycle after mtime reaches 32; r_mtip[0] stays 0.
- Timer clear: with mtip asserted, write 0x400C=1 -> r_mtip[1] drops the cycle after the write. Software IPI: write 0x0000=0xFFFFFFFF -> r_msip=2'b01 next cycle, read 0x0000 -> 1. Write 0 -> cleared.
- Wrap and priority: write 0xBFFC=0xFFFFFFFF and 0xBFF8=0xFFFFFFFE -> mtime reaches 2^64-1, then 0 on the following tick. Write 0xBFF8 on a tick cycle -> written value is kept and not incremented that cycle.
- Prescaler, TICK_DIV=4: after reset, mtime=3 after 12 cycles. Writing mtime does not disturb tick phase.
- Unmapped accesses: write 0x0008 (hart 2 msip, N_HARTS=2) and 0x1234 -> no state change; reads of both return 0 with r_rvalid. A read of 0xBFF8 asserted together with RST -> no r_rvalid.

Source files
------------

// File: rtl/clint_smp_if.sv
// MMIO slave bus between the memory controller and the CLINT: word-wide access strobe plus registered read return.
// Latency: read data returns one cycle after w_req; writes land at the request edge.
// Backpressure: none; every w_req is accepted in its cycle.
// Ports: w_req/w_we/w_addr/w_wdata (controller -> CLINT), r_rdata/r_rvalid (CLINT -> controller).
interface clint_smp_if;
  logic        w_req;
  logic        w_we;
  logic [15:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] r_rdata;
  logic        r_rvalid;

  modport master (output w_req, output w_we, output w_addr, output w_wdata,
                  input  r_rdata, input r_rvalid);
  modport slave  (input  w_req, input  w_we, input  w_addr, input  w_wdata,
                  output r_rdata, output r_rvalid);
endinterface

// File: rtl/clint_smp.sv
// Core-local interruptor: shared 64-bit mtime, per-hart mtimecmp and msip, per-hart timer/software interrupt outputs.
// Latency: writes take effect at the request edge; reads return 1 cycle later; r_mtip lags mtime/mtimecmp by 1 cycle.
// Backpressure: none; every MMIO access is accepted in the cycle it is presented.
// Ports: CLK, RST (sync, active-high); bus (clint_smp_if.slave); r_mtip/r_msip per hart; w_mtime = live mtime.
module clint_smp #(
  parameter int N_HARTS  = 2,
  parameter int TICK_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST,
  clint_smp_if.slave         bus,
  output logic [N_HARTS-1:0] r_mtip,
  output logic [N_HARTS-1:0] r_msip,
  output logic [63:0]        w_mtime
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp [N_HARTS];
  logic          tick;

  logic          rd;
  logic          wr;
  logic          sel_msip;
  logic          sel_cmp;
  logic          sel_mtime;
  logic [3:0]    msip_idx;
  logic [3:0]    cmp_idx;
  logic          hi_half;
  logic [31:0]   rd_dat;
  logic          addr_unused;

  // Byte lanes are not decoded; the word index is all that matters.
  assign addr_unused = ^bus.w_addr[1:0];

  assign tick     = (presc == PRESC_MAX);
  assign w_mtime  = mtime;

  assign rd       = bus.w_req & ~bus.w_we;
  assign wr       = bus.w_req &  bus.w_we;
  assign msip_idx = bus.w_addr[5:2];
  assign cmp_idx  = bus.w_addr[6:3];
  assign hi_half  = bus.w_addr[2];

  // Hart slots beyond N_HARTS fall out of the window and decode as unmapped.
  assign sel_msip  = (bus.w_addr[15:6] == 10'h000) && ({1'b0, msip_idx} < 5'(N_HARTS));
  assign sel_cmp   = (bus.w_addr[15:7] == 9'h080)  && ({1'b0, cmp_idx}  < 5'(N_HARTS));
  assign sel_mtime = (bus.w_addr[15:3] == 13'h17FF);

  // Read mux sees pre-edge state, so a read never observes a same-edge write.
  always_comb begin
    rd_dat = '0;
    for (int h = 0; h < N_HARTS; h++) begin
      if (sel_msip && (msip_idx == 4'(h)))
        rd_dat = {31'b0, r_msip[h]};
      if (sel_cmp && (cmp_idx == 4'(h)))
        rd_dat = hi_half ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
    end
    if (sel_mtime)
      rd_dat = hi_half ? mtime[63:32] : mtime[31:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc        <= '0;
      mtime        <= '0;
      r_mtip       <= '0;
      r_msip       <= '0;
      bus.r_rdata  <= '0;
      bus.r_rvalid <= 1'b0;
      for (int h = 0; h < N_HARTS; h++)
        mtimecmp[h] <= '1;
    end else begin
      bus.r_rvalid <= rd;
      if (rd)
        bus.r_rdata <= rd_dat;

      // Prescaler free-runs; mtime writes never touch its phase.
      presc <= tick ? '0 : presc + PW'(1);

      // A software write wins over the tick; the untouched half keeps its old value with no carry.
      if (wr && sel_mtime && !hi_half)
        mtime[31:0] <= bus.w_wdata;
      else if (wr && sel_mtime && hi_half)
        mtime[63:32] <= bus.w_wdata;
      else if (tick)
        mtime <= mtime + 64'd1;

      for (int h = 0; h < N_HARTS; h++) begin
        r_mtip[h] <= (mtime >= mtimecmp[h]);
        if (wr && sel_cmp && (cmp_idx == 4'(h))) begin
          if (hi_half)
            mtimecmp[h][63:32] <= bus.w_wdata;
          else
            mtimecmp[h][31:0]  <= bus.w_wdata;
        end
        if (wr && sel_msip && (msip_idx == 4'(h)))
          r_msip[h] <= bus.w_wdata[0];
      end
    end
  end

endmodule

// File: tb/tb_clint_smp.sv
// Bench for clint_smp: two instances (tick divider 1 and 4) driven with identical traffic, checked every cycle against a reference model.
// Latency: model outputs correspond to DUT state one edge after the inputs are applied.
// Backpressure: none modelled; the DUT accepts every access.
module tb_clint_smp;
  localparam int N = 2;

  logic        CLK;
  logic        RST;
  logic [N-1:0] mtip0, msip0, mtip4, msip4;
  logic [63:0] mtime0, mtime4;

  clint_smp_if bus0();
  clint_smp_if bus4();

  clint_smp #(.N_HARTS(N), .TICK_DIV(1)) dut0 (
    .CLK(CLK), .RST(RST), .bus(bus0), .r_mtip(mtip0), .r_msip(msip0), .w_mtime(mtime0));
  clint_smp #(.N_HARTS(N), .TICK_DIV(4)) dut4 (
    .CLK(CLK), .RST(RST), .bus(bus4), .r_mtip(mtip4), .r_msip(msip4), .w_mtime(mtime4));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state, index 0 = divider 1, index 1 = divider 4.
  logic [63:0]  m_mtime  [2];
  logic [63:0]  m_cmp    [2][N];
  logic [N-1:0] m_msip   [2];
  logic [N-1:0] m_mtip   [2];
  logic [31:0]  m_rdata  [2];
  logic         m_rvalid [2];
  int unsigned  m_cyc    [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input int k, input logic [15:0] addr);
    int unsigned a;
    a = int'(addr) & 32'hFFFC;
    if (a < 4 * N)
      return {31'b0, m_msip[k][a / 4]};
    if (a >= 32'h4000 && a < 32'h4000 + 8 * N) begin
      if (((a - 32'h4000) % 8) == 0)
        return m_cmp[k][(a - 32'h4000) / 8][31:0];
      return m_cmp[k][(a - 32'h4000) / 8][63:32];
    end
    if (a == 32'hBFF8) return m_mtime[k][31:0];
    if (a == 32'hBFFC) return m_mtime[k][63:32];
    return 32'h0;
  endfunction

  task automatic model_step(input int k, input logic rst, input logic req, input logic we,
                            input logic [15:0] addr, input logic [31:0] wd);
    int unsigned a;
    int unsigned td;
    logic [63:0] old;
    bit tick;
    td = (k == 0) ? 1 : 4;
    if (rst) begin
      m_mtime[k]  = '0;
      m_cyc[k]    = 0;
      m_msip[k]   = '0;
      m_mtip[k]   = '0;
      m_rdata[k]  = '0;
      m_rvalid[k] = 1'b0;
      for (int h = 0; h < N; h++) m_cmp[k][h] = '1;
      return;
    end
    for (int h = 0; h < N; h++) m_mtip[k][h] = (m_mtime[k] >= m_cmp[k][h]);
    m_rvalid[k] = req && !we;
    if (req && !we) m_rdata[k] = m_read(k, addr);
    tick = ((m_cyc[k] % td) == td - 1);
    m_cyc[k]++;
    a   = int'(addr) & 32'hFFFC;
    old = m_mtime[k];
    if (req && we && a == 32'hBFF8)      m_mtime[k] = {old[63:32], wd};
    else if (req && we && a == 32'hBFFC) m_mtime[k] = {wd, old[31:0]};
    else if (tick)                       m_mtime[k] = old + 64'd1;
    if (req && we && a >= 32'h4000 && a < 32'h4000 + 8 * N) begin
      if (((a - 32'h4000) % 8) == 0) m_cmp[k][(a - 32'h4000) / 8][31:0]  = wd;
      else                           m_cmp[k][(a - 32'h4000) / 8][63:32] = wd;
    end
    if (req && we && a < 4 * N) m_msip[k][a / 4] = wd[0];
  endtask

  task automatic check_model();
    chk("i0 rvalid", 64'(bus0.r_rvalid), 64'(m_rvalid[0]));
    chk("i0 rdata",  64'(bus0.r_rdata),  64'(m_rdata[0]));
    chk("i0 mtip",   64'(mtip0),         64'(m_mtip[0]));
    chk("i0 msip",   64'(msip0),         64'(m_msip[0]));
    chk("i0 mtime",  mtime0,             m_mtime[0]);
    chk("i1 rvalid", 64'(bus4.r_rvalid), 64'(m_rvalid[1]));
    chk("i1 rdata",  64'(bus4.r_rdata),  64'(m_rdata[1]));
    chk("i1 mtip",   64'(mtip4),         64'(m_mtip[1]));
    chk("i1 msip",   64'(msip4),         64'(m_msip[1]));
    chk("i1 mtime",  mtime4,             m_mtime[1]);
  endtask

  // Called at a falling edge: apply inputs, advance the model, cross the rising edge, compare.
  task automatic step(input logic rst, input logic req, input logic we,
                      input logic [15:0] addr, input logic [31:0] wd);
    RST = rst;
    bus0.w_req = req; bus0.w_we = we; bus0.w_addr = addr; bus0.w_wdata = wd;
    bus4.w_req = req; bus4.w_we = we; bus4.w_addr = addr; bus4.w_wdata = wd;
    model_step(0, rst, req, we, addr, wd);
    model_step(1, rst, req, we, addr, wd);
    @(negedge CLK);
    check_model();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] wd);
    step(1'b0, 1'b1, 1'b1, addr, wd);
  endtask

  task automatic rd(input logic [15:0] addr);
    step(1'b0, 1'b1, 1'b0, addr, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  initial begin
    logic [15:0] addr;
    logic [31:0] wd;
    logic        req, we, rst;
    int          sel;
    bit          fired;

    RST = 1'b1;
    bus0.w_req = 1'b0; bus0.w_we = 1'b0; bus0.w_addr = '0; bus0.w_wdata = '0;
    bus4.w_req = 1'b0; bus4.w_we = 1'b0; bus4.w_addr = '0; bus4.w_wdata = '0;
    @(negedge CLK);

    // Reset values and prescaler phase from reset release.
    do_reset();
    chk("rst mtip", 64'(mtip0), 64'h0);
    chk("rst msip", 64'(msip0), 64'h0);
    rd(16'hBFF8);
    chk("rst rd mtime vld", 64'(bus0.r_rvalid), 64'h1);
    chk("rst rd mtime dat", 64'(bus0.r_rdata),  64'h0);
    rd(16'h4000);
    chk("rst rd cmp dat", 64'(bus0.r_rdata), 64'hFFFF_FFFF);
    chk("rvalid pulse",   64'(bus4.r_rvalid), 64'h1);
    for (int i = 0; i < 10; i++) idle();
    chk("rvalid single", 64'(bus0.r_rvalid), 64'h0);
    chk("rdata hold",    64'(bus0.r_rdata),  64'hFFFF_FFFF);
    chk("div4 mtime@12", mtime4, 64'd3);
    chk("div1 mtime@12", mtime0, 64'd12);

    // Timer fire on hart 1 one cycle after mtime reaches 32.
    do_reset();
    wr(16'h4008, 32'h20);
    wr(16'h400C, 32'h0);
    fired = 0;
    for (int i = 0; i < 100 && !fired; i++) begin
      idle();
      if (mtime0 == 64'd32) chk("mtip before fire", 64'(mtip0), 64'h0);
      if (mtime0 == 64'd33) begin
        chk("mtip fire", 64'(mtip0), 64'h2);
        fired = 1;
      end
    end
    if (!fired) chk("mtip fire timeout", 64'h0, 64'h1);

    // Raising mtimecmp clears mtip one cycle later.
    wr(16'h400C, 32'h1);
    chk("mtip at cmp write", 64'(mtip0), 64'h2);
    idle();
    chk("mtip cleared", 64'(mtip0), 64'h0);

    // Software interrupt: only bit 0 stored.
    wr(16'h0000, 32'hFFFF_FFFF);
    chk("msip set", 64'(msip0), 64'h1);
    rd(16'h0000);
    chk("msip read", 64'(bus0.r_rdata), 64'h1);
    wr(16'h0000, 32'h0);
    chk("msip clear", 64'(msip0), 64'h0);

    // 64-bit wrap, then write-over-tick priority.
    wr(16'hBFFC, 32'hFFFF_FFFF);
    wr(16'hBFF8, 32'hFFFF_FFFE);
    chk("mtime preset", mtime0, 64'hFFFF_FFFF_FFFF_FFFE);
    idle();
    chk("mtime max", mtime0, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    chk("mtime wrap", mtime0, 64'h0);
    wr(16'hBFF8, 32'h100);
    chk("mtime write prio", mtime0, 64'h100);

    // Unmapped slots: hart 2 msip and a hole in the map.
    wr(16'h0008, 32'h1);
    wr(16'h1234, 32'hDEAD_BEEF);
    chk("unmapped no msip", 64'(msip0), 64'h0);
    rd(16'h0008);
    chk("unmapped rd vld", 64'(bus0.r_rvalid), 64'h1);
    chk("unmapped rd dat", 64'(bus0.r_rdata),  64'h0);
    rd(16'h1234);
    chk("hole rd dat", 64'(bus0.r_rdata), 64'h0);

    // A read presented with reset is dropped.
    step(1'b1, 1'b1, 1'b0, 16'hBFF8, 32'h0);
    chk("rst drops read", 64'(bus0.r_rvalid), 64'h0);

    // Randomized traffic, biased toward mapped registers and values near mtime.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      req = ($urandom_range(0, 9) < 7);
      we  = $urandom_range(0, 1) != 0;
      sel = $urandom_range(0, 7);
      wd  = $urandom;
      case (sel)
        0: addr = 16'(4 * $urandom_range(0, 3));
        1, 2: begin
          addr = 16'(32'h4000 + 8 * $urandom_range(0, 3));
          wd   = m_mtime[0][31:0] + 32'($urandom_range(0, 60)) - 32'd30;
        end
        3: begin
          addr = 16'(32'h4004 + 8 * $urandom_range(0, 3));
          wd   = ($urandom_range(0, 3) == 0) ? $urandom : m_mtime[0][63:32];
        end
        4: begin
          addr = 16'hBFF8;
          if ($urandom_range(0, 1) != 0) wd = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        end
        5: begin
          addr = 16'hBFFC;
          wd   = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
        end
        6: addr = 16'($urandom);
        default: addr = 16'h1234;
      endcase
      addr = addr | 16'($urandom_range(0, 3));
      step(rst, req, we, addr, wd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
